dma_priority_arbiter: RTL

Request-side front end of the 8237A-style DMA controller. It conditions the four DREQ inputs against DREQ polarity, mask bits and software requests, and resolves them under fixed or rotating priority. It presents exactly one one-hot channel request to the timing-control FSM on `VALID_DREQ` and drives the matching `DACK` line while that FSM reports an active service cycle. It sits directly upstream of the timing-control block and feeds its `VALID_DREQ0..3` inputs.

---
 rtl/dma_priority_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dma_priority_arbiter.sv
// DMA request conditioning and fixed/rotating priority arbiter for a four-channel 8237A-style controller.
// Define DMA_ROTATE_PRIORITY_EN to build in the rotating-priority pointer; without it, priority is fixed.
module dma_priority_arbiter #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     commandReg,
  input  logic [NCH-1:0] maskReg,
  input  logic [NCH-1:0] requestReg,
  input  logic           validDACK,
  input  logic           serviceDone,
  output logic [NCH-1:0] VALID_DREQ,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     grantCh,
  output logic           grantValid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] dreq_q, dreq_d;
  logic [1:0]     grant_ch_q, grant_ch_d;
  logic [NCH-1:0] valid_dreq_q, valid_dreq_d;
  logic           grant_valid_q, grant_valid_d;
  logic [NCH-1:0] eff_req;
  logic [NCH-1:0] ack_onehot;
  logic [1:0]     top_eff;
  logic [1:0]     scan_idx;
  logic [1:0]     win_ch;
  logic           win_found;

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [1:0] top_q, top_d;
  assign top_eff = commandReg[4] ? top_q : 2'd0;
`else
  assign top_eff = 2'd0;
`endif

  assign eff_req = (dreq_q & ~maskReg) | requestReg;

  // Scan starting at the highest-priority channel, wrapping past the last one.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      scan_idx = top_eff + k[1:0];
      if (!win_found && eff_req[scan_idx]) begin
        win_found = 1'b1;
        win_ch    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    dreq_d     = DREQ ^ {NCH{commandReg[6]}};
`ifdef DMA_ROTATE_PRIORITY_EN
    top_d      = top_q;
`endif
    case (state_q)
      IDLE: begin
        if (!commandReg[2] && win_found) begin
          state_d    = GRANT;
          grant_ch_d = win_ch;
        end
      end
      GRANT: begin
        if (validDACK) begin
          state_d = SERVICE;
        end else if (commandReg[2] || !eff_req[grant_ch_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (serviceDone) begin
          state_d = IDLE;
`ifdef DMA_ROTATE_PRIORITY_EN
          if (commandReg[4]) top_d = grant_ch_q + 2'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    valid_dreq_d  = '0;
    grant_valid_d = (state_d != IDLE);
    if (state_d != IDLE) valid_dreq_d[grant_ch_d] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      dreq_q        <= '0;
      grant_ch_q    <= '0;
      valid_dreq_q  <= '0;
      grant_valid_q <= 1'b0;
`ifdef DMA_ROTATE_PRIORITY_EN
      top_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      dreq_q        <= dreq_d;
      grant_ch_q    <= grant_ch_d;
      valid_dreq_q  <= valid_dreq_d;
      grant_valid_q <= grant_valid_d;
`ifdef DMA_ROTATE_PRIORITY_EN
      top_q         <= top_d;
`endif
    end
  end

  assign ack_onehot = (state_q == SERVICE && validDACK) ? valid_dreq_q : '0;
  assign DACK       = ack_onehot ^ {NCH{~commandReg[7]}};
  assign VALID_DREQ = valid_dreq_q;
  assign grantCh    = grant_ch_q;
  assign grantValid = grant_valid_q;

endmodule
